// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: steps each instruction through fetch/decode/execute/memory/
// writeback and drives datapath selects and strobes; stalled memory accesses time out into FAULT.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dest,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic       fault,
    output logic [3:0] state_o
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LW_WB    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_JAL      = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_JR       = 4'd13,
        S_FAULT    = 4'd15
    } state_t;

    // Moore control word; in_* flags qualify the few strobes that also depend on live inputs
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] reg_dest;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       fault;
        logic       in_fetch;
        logic       in_decode;
        logic       in_beq;
    } ctrl_t;

    state_t           state;
    state_t           state_next;
    state_t           dispatch_c;
    logic             legal_c;
    logic             timeout_c;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    ctrl_t            ctrl_d;
    ctrl_t            ctrl_q;

    // Instruction dispatch target from the IR fields
    always_comb begin
        dispatch_c = S_FETCH;
        legal_c    = 1'b1;
        case (opcode)
            OP_LW, OP_SW: dispatch_c = S_MEM_ADDR;
            OP_RTYPE:     dispatch_c = (funct == FN_JR) ? S_JR : S_R_EX;
            OP_BEQ:       dispatch_c = S_BEQ;
            OP_ADDI:      dispatch_c = S_ADDI_EX;
            OP_J:         dispatch_c = S_JUMP;
            OP_JAL:       dispatch_c = S_JAL;
            default:      legal_c    = 1'b0;
        endcase
    end

    assign timeout_c = (wait_cnt == CNT_LAST);

    // Next-state and wait counter; counter returns to zero on every state change
    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        case (state)
            S_FETCH: begin
                // the cycle right after reset release has no request outstanding yet
                if (ctrl_q.mem_read) begin
                    if (mem_ack)        state_next    = S_DECODE;
                    else if (timeout_c) state_next    = S_FAULT;
                    else                wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE:   state_next = dispatch_c;
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ack)        state_next    = S_LW_WB;
                else if (timeout_c) state_next    = S_FAULT;
                else                wait_cnt_next = wait_cnt + CNT_W'(1);
            end
            S_MEM_WR: begin
                if (mem_ack)        state_next    = S_FETCH;
                else if (timeout_c) state_next    = S_FAULT;
                else                wait_cnt_next = wait_cnt + CNT_W'(1);
            end
            S_R_EX:    state_next = S_R_WB;
            S_ADDI_EX: state_next = S_ADDI_WB;
            S_LW_WB, S_R_WB, S_ADDI_WB,
            S_BEQ, S_JUMP, S_JAL, S_JR: state_next = S_FETCH;
            S_FAULT:   state_next = S_FAULT;
            default:   state_next = S_FAULT;
        endcase
    end

    // Control word decoded from the next state so the registered outputs line up with state
    always_comb begin
        ctrl_d = '0;
        case (state_next)
            S_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.in_fetch  = 1'b1;
            end
            S_DECODE: begin
                ctrl_d.alu_src_b = 2'b11;
                ctrl_d.in_decode = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.i_or_d   = 1'b1;
            end
            S_LW_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
            end
            S_R_EX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            S_R_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dest  = 2'b01;
            end
            S_BEQ: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b01;
                ctrl_d.pc_src    = 2'b01;
                ctrl_d.in_beq    = 1'b1;
            end
            S_ADDI_WB: ctrl_d.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 2'b10;
            end
            S_JAL: begin
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.pc_src     = 2'b10;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dest   = 2'b10;
                ctrl_d.mem_to_reg = 2'b10;
            end
            S_JR: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 2'b11;
            end
            S_FAULT: ctrl_d.fault = 1'b1;
            default: ctrl_d.fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            ctrl_q   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ctrl_q   <= ctrl_d;
        end
    end

    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign i_or_d     = ctrl_q.i_or_d;
    assign pc_src     = ctrl_q.pc_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_dest   = ctrl_q.reg_dest;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign fault      = ctrl_q.fault;
    assign state_o    = state;

    // Same-cycle strobes: fetch completion and the branch decision
    assign ir_write = ctrl_q.in_fetch & mem_ack;
    assign pc_write = ctrl_q.pc_write | (ctrl_q.in_fetch & mem_ack) | (ctrl_q.in_beq & zero);
    assign illegal  = ctrl_q.in_decode & ~legal_c;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class, wait states, timeout and resets.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dest;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       fault;
    logic [3:0] state_o;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // strobes: {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, illegal, fault}
    localparam logic [7:0] B_NONE  = 8'b0000_0000;
    localparam logic [7:0] B_FETCH = 8'b1000_0000;
    localparam logic [7:0] B_FACK  = 8'b1001_1000;
    localparam logic [7:0] B_MRD   = 8'b1010_0000;
    localparam logic [7:0] B_MWR   = 8'b0110_0000;
    localparam logic [7:0] B_RW    = 8'b0000_0100;
    localparam logic [7:0] B_PCW   = 8'b0000_1000;
    localparam logic [7:0] B_JAL   = 8'b0000_1100;
    localparam logic [7:0] B_ILL   = 8'b0000_0010;
    localparam logic [7:0] B_FLT   = 8'b0000_0001;

    // muxes: {pc_src, alu_src_a, alu_src_b, alu_op, reg_dest, mem_to_reg}
    localparam logic [10:0] M_ZERO   = 11'b00_0_00_00_00_00;
    localparam logic [10:0] M_FETCH  = 11'b00_0_01_00_00_00;
    localparam logic [10:0] M_DECODE = 11'b00_0_11_00_00_00;
    localparam logic [10:0] M_MADDR  = 11'b00_1_10_00_00_00;
    localparam logic [10:0] M_LWWB   = 11'b00_0_00_00_00_01;
    localparam logic [10:0] M_REX    = 11'b00_1_00_10_00_00;
    localparam logic [10:0] M_RWB    = 11'b00_0_00_00_01_00;
    localparam logic [10:0] M_BEQ    = 11'b01_1_00_01_00_00;
    localparam logic [10:0] M_JUMP   = 11'b10_0_00_00_00_00;
    localparam logic [10:0] M_JAL    = 11'b10_0_00_00_10_10;
    localparam logic [10:0] M_JR     = 11'b11_0_00_00_00_00;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dest   (reg_dest),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .fault      (fault),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] st,
                                input logic [7:0] strb, input logic [10:0] mux);
        chk({tag, " state"}, 32'(state_o), 32'(st));
        chk({tag, " strobes"}, 32'({mem_read, mem_write, i_or_d, ir_write, pc_write,
                                     reg_write, illegal, fault}), 32'(strb));
        chk({tag, " muxes"}, 32'({pc_src, alu_src_a, alu_src_b, alu_op, reg_dest, mem_to_reg}),
            32'(mux));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Acks the fetch in the current cycle, then checks the DECODE cycle that follows
    task automatic fetch_ack(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [7:0] dec_strb);
        opcode  = op;
        funct   = fn;
        mem_ack = 1'b1;
        #1;
        expect_cycle({tag, " fetch ack"}, 4'd0, B_FACK, M_FETCH);
        next_cycle();
        mem_ack = 1'b0;
        #1;
        expect_cycle({tag, " decode"}, 4'd1, dec_strb, M_DECODE);
    endtask

    task automatic expect_fetch(input string tag);
        next_cycle();
        #1;
        expect_cycle(tag, 4'd0, B_FETCH, M_FETCH);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        expect_cycle("in reset", 4'd0, B_NONE, M_ZERO);
        next_cycle();
        mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        expect_cycle("release", 4'd0, B_NONE, M_ZERO);
        expect_fetch("first fetch");

        // lw, zero wait states: 0,1,2,3,4,0
        fetch_ack("lw", OP_LW, 6'd0, B_NONE);
        next_cycle(); #1;
        expect_cycle("lw addr", 4'd2, B_NONE, M_MADDR);
        next_cycle(); mem_ack = 1'b1; #1;
        expect_cycle("lw rd", 4'd3, B_MRD, M_ZERO);
        next_cycle(); mem_ack = 1'b0; #1;
        expect_cycle("lw wb", 4'd4, B_RW, M_LWWB);
        expect_fetch("lw done");

        // sw acked after five wait cycles
        fetch_ack("sw", OP_SW, 6'd0, B_NONE);
        next_cycle(); #1;
        expect_cycle("sw addr", 4'd2, B_NONE, M_MADDR);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            mem_ack = (i == 5);
            #1;
            expect_cycle("sw wait", 4'd5, B_MWR, M_ZERO);
        end
        next_cycle(); mem_ack = 1'b0; #1;
        expect_cycle("sw done", 4'd0, B_FETCH, M_FETCH);

        // beq: pc_write follows zero within the cycle
        fetch_ack("beq", OP_BEQ, 6'd0, B_NONE);
        next_cycle(); zero = 1'b1; #1;
        expect_cycle("beq taken", 4'd8, B_PCW, M_BEQ);
        zero = 1'b0; #1;
        expect_cycle("beq not taken", 4'd8, B_NONE, M_BEQ);
        expect_fetch("beq done");

        fetch_ack("jal", OP_JAL, 6'd0, B_NONE);
        next_cycle(); #1;
        expect_cycle("jal", 4'd10, B_JAL, M_JAL);
        expect_fetch("jal done");

        fetch_ack("add", OP_R, 6'b100000, B_NONE);
        next_cycle(); #1;
        expect_cycle("r ex", 4'd6, B_NONE, M_REX);
        next_cycle(); #1;
        expect_cycle("r wb", 4'd7, B_RW, M_RWB);
        expect_fetch("r done");

        fetch_ack("jr", OP_R, 6'b001000, B_NONE);
        next_cycle(); #1;
        expect_cycle("jr", 4'd13, B_PCW, M_JR);
        expect_fetch("jr done");

        fetch_ack("addi", OP_ADDI, 6'd0, B_NONE);
        next_cycle(); #1;
        expect_cycle("addi ex", 4'd11, B_NONE, M_MADDR);
        next_cycle(); #1;
        expect_cycle("addi wb", 4'd12, B_RW, M_ZERO);
        expect_fetch("addi done");

        fetch_ack("illegal", OP_BAD, 6'd0, B_ILL);
        expect_fetch("after illegal");

        // fetch acked on its 16th cycle still decodes
        for (int i = 2; i <= 15; i++) expect_fetch("fetch stall");
        next_cycle();
        fetch_ack("late ack j", OP_J, 6'd0, B_NONE);
        next_cycle(); #1;
        expect_cycle("jump", 4'd9, B_PCW, M_JUMP);
        expect_fetch("jump done");

        // no ack for 16 fetch cycles -> FAULT, absorbing
        for (int i = 2; i <= 16; i++) expect_fetch("fetch timeout wait");
        next_cycle(); #1;
        expect_cycle("fault entry", 4'd15, B_FLT, M_ZERO);
        mem_ack = 1'b1; zero = 1'b1;
        repeat (3) next_cycle();
        #1;
        expect_cycle("fault sticky", 4'd15, B_FLT, M_ZERO);
        rst = 1'b0; #1;
        expect_cycle("fault reset", 4'd0, B_NONE, M_ZERO);
        mem_ack = 1'b0; zero = 1'b0;
        next_cycle(); rst = 1'b1; #1;
        expect_cycle("fault release", 4'd0, B_NONE, M_ZERO);
        expect_fetch("refetch");

        // reset while a load waits in MEM_RD
        fetch_ack("lw abort", OP_LW, 6'd0, B_NONE);
        next_cycle(); #1;
        expect_cycle("abort addr", 4'd2, B_NONE, M_MADDR);
        next_cycle(); #1;
        expect_cycle("abort rd", 4'd3, B_MRD, M_ZERO);
        rst = 1'b0; #1;
        expect_cycle("rst in mem_rd", 4'd0, B_NONE, M_ZERO);
        mem_ack = 1'b1;
        next_cycle(); #1;
        expect_cycle("rst held", 4'd0, B_NONE, M_ZERO);
        mem_ack = 1'b0; rst = 1'b1; #1;
        expect_cycle("abort release", 4'd0, B_NONE, M_ZERO);
        expect_fetch("abort refetch");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
